// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan controller and the 4:1 mux stage / frame consumer.
// With MUX_SCAN_PARITY_EN defined, the bundle also carries the frame parity bit.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       pause;
  logic       abort;
  logic       y;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] frame_out;
  logic       frame_valid;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_par;

  modport master (
    output start, cont, pause, abort, y,
    input  sel, busy, frame_out, frame_valid, frame_par
  );
  modport slave (
    input  start, cont, pause, abort, y,
    output sel, busy, frame_out, frame_valid, frame_par
  );
`else
  modport master (
    output start, cont, pause, abort, y,
    input  sel, busy, frame_out, frame_valid
  );
  modport slave (
    input  start, cont, pause, abort, y,
    output sel, busy, frame_out, frame_valid
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans mux channels 0..3 with a programmable dwell and emits a 4-bit sample frame per scan.
// Optional MUX_SCAN_PARITY_EN adds a registered even-parity bit alongside the frame.
module mux_scan_ctrl #(
  parameter  int DWELL = 4,
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t        state;
  logic [1:0]    chan;
  logic [CW-1:0] cnt;
  logic [3:0]    acc;
  logic [3:0]    acc_nxt;
  logic [3:0]    frame_q;
  logic          busy_q;
  logic          valid_q;

  // Accumulator with the current sample merged in; on channel 3 this is the whole frame.
  always_comb begin
    acc_nxt       = acc;
    acc_nxt[chan] = bus.y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      chan    <= 2'd0;
      cnt     <= '0;
      acc     <= 4'd0;
      frame_q <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          chan <= 2'd0;
          cnt  <= '0;
          if (bus.start) begin
            state  <= ST_SCAN;
            busy_q <= 1'b1;
            acc    <= 4'd0;
          end
        end
        ST_SCAN: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            chan   <= 2'd0;
            cnt    <= '0;
          end else if (!bus.pause) begin
            if (cnt != CNT_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              acc <= acc_nxt;
              if (chan != 2'd3) begin
                chan <= chan + 2'd1;
              end else begin
                frame_q <= acc_nxt;
                valid_q <= 1'b1;
                chan    <= 2'd0;
                if (!bus.cont) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                end
              end
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          chan   <= 2'd0;
          cnt    <= '0;
        end
      endcase
    end
  end

  // sel is the channel register itself, so it can never disagree with chan.
  assign bus.sel         = chan;
  assign bus.busy        = busy_q;
  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = valid_q;

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (state == ST_SCAN && !bus.abort && !bus.pause &&
                 cnt == CNT_LAST && chan == 2'd3) begin
      par_q <= ^acc_nxt;
    end
  end

  assign bus.frame_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed vector table, hand sequences, random vs. model.
// Parity checks are compiled in when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_ctrl;

  localparam int DW0 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d0;
  logic [3:0] d1;
  int         n_total = 0;
  int         n_pass  = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();

  assign bus0.y = d0[bus0.sel];
  assign bus1.y = d1[bus1.sel];

  mux_scan_ctrl #(.DWELL(DW0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_scan_ctrl #(.DWELL(1))   u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counts active (unpaused) scan cycles and derives channel/sample points arithmetically.
  int         m_n;
  bit         m_busy;
  bit         m_valid;
  logic [3:0] m_acc;
  logic [3:0] m_frame;

  function automatic logic [1:0] m_sel();
    return m_busy ? 2'(m_n / DW0) : 2'd0;
  endfunction

  task automatic model_edge(input bit r, input bit st, input bit ct, input bit pa,
                            input bit ab, input bit yv);
    int k;
    m_valid = 1'b0;
    if (!r) begin
      m_busy = 0; m_n = 0; m_frame = 4'd0; m_acc = 4'd0;
    end else if (!m_busy) begin
      if (st) begin m_busy = 1; m_n = 0; m_acc = 4'd0; end
    end else if (ab) begin
      m_busy = 0; m_n = 0;
    end else if (!pa) begin
      m_n++;
      if (m_n % DW0 == 0) begin
        k = m_n / DW0 - 1;
        m_acc[k] = yv;
        if (k == 3) begin
          m_frame = m_acc; m_valid = 1; m_n = 0;
          if (!ct) m_busy = 0;
        end
      end
    end
  endtask

  typedef struct {
    logic [3:0] d;
    int         pause_at;
    int         pause_len;
    int         abort_at;
    bit         exp_seen;
    logic [3:0] exp_frame;
    int         exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, cnt_v, c;
    int t[3];
    logic [3:0] f[3];
    bit aborted;

    tbl[0] = '{d: 4'b1010, pause_at: -1, pause_len: 0, abort_at: -1, exp_seen: 1, exp_frame: 4'b1010, exp_lat: 16};
    tbl[1] = '{d: 4'b0111, pause_at: -1, pause_len: 0, abort_at: -1, exp_seen: 1, exp_frame: 4'b0111, exp_lat: 16};
    tbl[2] = '{d: 4'b1101, pause_at: 9,  pause_len: 3, abort_at: -1, exp_seen: 1, exp_frame: 4'b1101, exp_lat: 19};
    tbl[3] = '{d: 4'b0010, pause_at: -1, pause_len: 0, abort_at: 5,  exp_seen: 0, exp_frame: 4'b1101, exp_lat: 0};
    tbl[4] = '{d: 4'b0110, pause_at: -1, pause_len: 0, abort_at: -1, exp_seen: 1, exp_frame: 4'b0110, exp_lat: 16};

    d0 = 4'd0; d1 = 4'd0;
    bus0.start = 0; bus0.cont = 0; bus0.pause = 0; bus0.abort = 0;
    bus1.start = 0; bus1.cont = 0; bus1.pause = 0; bus1.abort = 0;

    // Reset with start held high
    rst_n = 0; bus0.start = 1; bus1.start = 1;
    repeat (3) step();
    chk("rst_sel", bus0.sel, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_valid", bus0.frame_valid, 0);
    chk("rst_frame", bus0.frame_out, 0);
    chk("rst_busy_dw1", bus1.busy, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_par", bus0.frame_par, 0);
`endif
    bus0.start = 0; bus1.start = 0;
    rst_n = 1;
    step();

    // Directed vector table on the DWELL=4 instance
    for (int i = 0; i < 5; i++) begin
      d0 = tbl[i].d;
      bus0.start = 1;
      step();
      bus0.start = 0;
      chk($sformatf("v%0d_start_busy", i), bus0.busy, 1);
      chk($sformatf("v%0d_start_sel", i), bus0.sel, 0);
      lat = -1; aborted = 0;
      for (c = 1; c <= 40; c++) begin
        bus0.pause = (tbl[i].pause_at >= 0) && (c >= tbl[i].pause_at) &&
                     (c < tbl[i].pause_at + tbl[i].pause_len);
        bus0.abort = (c == tbl[i].abort_at);
        step();
        if (bus0.pause) chk($sformatf("v%0d_pause_sel", i), bus0.sel, 2);
        if (bus0.frame_valid) begin lat = c; break; end
        if (bus0.abort) begin aborted = 1; break; end
      end
      bus0.pause = 0; bus0.abort = 0;
      if (tbl[i].exp_seen) begin
        chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
        chk($sformatf("v%0d_frame", i), bus0.frame_out, tbl[i].exp_frame);
        chk($sformatf("v%0d_busy_fall", i), bus0.busy, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk($sformatf("v%0d_par", i), bus0.frame_par, ^tbl[i].exp_frame);
`endif
        step();
        chk($sformatf("v%0d_strobe_1cyc", i), bus0.frame_valid, 0);
      end else begin
        chk($sformatf("v%0d_aborted", i), aborted, 1);
        chk($sformatf("v%0d_abort_busy", i), bus0.busy, 0);
        chk($sformatf("v%0d_abort_sel", i), bus0.sel, 0);
        chk($sformatf("v%0d_abort_valid", i), bus0.frame_valid, 0);
        chk($sformatf("v%0d_abort_frame", i), bus0.frame_out, tbl[i].exp_frame);
      end
    end

    // Continuous mode with new data before the second frame's channel-0 sample, cont dropped in frame 3
    d0 = 4'b1010; bus0.cont = 1; bus0.start = 1;
    step();
    bus0.start = 0;
    cnt_v = 0;
    for (c = 1; c <= 60; c++) begin
      if (c == 17) d0 = 4'b0111;
      if (c == 40) bus0.cont = 0;
      step();
      if (bus0.frame_valid) begin
        if (cnt_v < 3) begin t[cnt_v] = c; f[cnt_v] = bus0.frame_out; end
        cnt_v++;
      end
      if (!bus0.busy) break;
    end
    chk("cont_count", cnt_v, 3);
    chk("cont_t0", t[0], 16);
    chk("cont_t1", t[1], 32);
    chk("cont_t2", t[2], 48);
    chk("cont_f0", f[0], 4'b1010);
    chk("cont_f1", f[1], 4'b0111);
    chk("cont_f2", f[2], 4'b0111);

    // Start in the strobe cycle of a one-shot end is accepted
    bus0.start = 1;
    step();
    bus0.start = 0;
    chk("restart_busy", bus0.busy, 1);
    lat = -1;
    for (c = 1; c <= 30; c++) begin
      step();
      if (bus0.frame_valid) begin lat = c; break; end
    end
    chk("restart_lat", lat, 16);
    chk("restart_frame", bus0.frame_out, 4'b0111);

    // DWELL=1: every cycle samples, start while busy is ignored
    d1 = 4'b1001; bus1.start = 1;
    step();
    bus1.start = 0;
    lat = -1;
    for (c = 1; c <= 10; c++) begin
      bus1.start = (c == 2);
      step();
      if (c < 4) chk($sformatf("dw1_sel_c%0d", c), bus1.sel, c);
      if (bus1.frame_valid) begin lat = c; break; end
    end
    bus1.start = 0;
    chk("dw1_lat", lat, 4);
    chk("dw1_frame", bus1.frame_out, 4'b1001);
    chk("dw1_busy_end", bus1.busy, 0);
    cnt_v = 0;
    repeat (8) begin
      step();
      if (bus1.frame_valid || bus1.busy) cnt_v++;
    end
    chk("dw1_no_requeue", cnt_v, 0);

    // Reset in the middle of a scan
    d0 = 4'b1111; bus0.start = 1;
    step();
    bus0.start = 0;
    repeat (9) step();
    rst_n = 0;
    step();
    chk("midrst_sel", bus0.sel, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_valid", bus0.frame_valid, 0);
    chk("midrst_frame", bus0.frame_out, 0);
    rst_n = 1;
    cnt_v = 0;
    repeat (20) begin
      step();
      if (bus0.frame_valid) cnt_v++;
    end
    chk("midrst_no_strobe", cnt_v, 0);

    // Randomized run against the reference model
    for (int i = 0; i < 500; i++) begin
      bit r, st, ct, pa, ab;
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      ct = $urandom_range(0, 1);
      pa = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) d0 = 4'($urandom_range(0, 15));
      rst_n = r; bus0.start = st; bus0.cont = ct; bus0.pause = pa; bus0.abort = ab;
      model_edge(r, st, ct, pa, ab, d0[m_sel()]);
      step();
      chk($sformatf("rnd%0d_sel", i), bus0.sel, m_sel());
      chk($sformatf("rnd%0d_busy", i), bus0.busy, m_busy);
      chk($sformatf("rnd%0d_valid", i), bus0.frame_valid, m_valid);
      chk($sformatf("rnd%0d_frame", i), bus0.frame_out, m_frame);
`ifdef MUX_SCAN_PARITY_EN
      chk($sformatf("rnd%0d_par", i), bus0.frame_par, ^m_frame);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
